// File: rtl/shim_abs_sample_collector.sv
// Collects one 16-bit sample per channel (8 channels), converts each to a saturated
// 15-bit magnitude and commits a complete set atomically; flags duplicate and stall faults.
module shim_abs_sample_collector #(
    parameter bit OFFSET_BINARY = 1'b0,
    parameter int TIMEOUT       = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sample_valid,
    input  logic [2:0]    sample_ch,
    input  logic [15:0]   sample_data,
    output logic [119:0]  abs_sample_concat,
    output logic          concat_valid,
    output logic          sample_core_done,
    output logic          err_duplicate,
    output logic          err_timeout,
    output logic          abs_saturated
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, ERROR} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [7:0]     bitmap_q, bitmap_d;
    logic [119:0]   shadow_q, shadow_d;
    logic [119:0]   concat_q, concat_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           concat_valid_q, concat_valid_d;
    logic           done_q, done_d;
    logic           err_dup_q, err_dup_d;
    logic           err_to_q, err_to_d;
    logic           sat_q, sat_d;

    logic [15:0]    s_word;
    logic           s_is_min;
    logic [14:0]    abs_word;
    logic           commit;

    // -32768 has no positive 16-bit counterpart, so it clips to the largest magnitude.
    function automatic logic [14:0] abs_sat15(input logic signed [15:0] s);
        logic signed [15:0] neg;
        neg = -s;
        if (s == 16'sh8000)
            return 15'h7FFF;
        else if (s < 0)
            return neg[14:0];
        else
            return s[14:0];
    endfunction

    always_comb begin
        s_word   = OFFSET_BINARY ? (sample_data ^ 16'h8000) : sample_data;
        s_is_min = (s_word == 16'h8000);
        abs_word = abs_sat15(s_word);
    end

    always_comb begin
        state_d        = state_q;
        bitmap_d       = bitmap_q;
        shadow_d       = shadow_q;
        concat_d       = concat_q;
        cnt_d          = cnt_q;
        concat_valid_d = 1'b0;
        done_d         = done_q;
        err_dup_d      = err_dup_q;
        err_to_d       = err_to_q;
        sat_d          = sat_q;
        commit         = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = PRIME;
                    bitmap_d = 8'h00;
                    cnt_d    = 16'd0;
                end
            end
            PRIME, RUN: begin
                if (!enable) begin
                    state_d  = IDLE;
                    bitmap_d = 8'h00;
                    cnt_d    = 16'd0;
                    done_d   = 1'b0;
                end else begin
                    if (sample_valid) begin
                        if (bitmap_q[sample_ch]) begin
                            err_dup_d = 1'b1;
                            state_d   = ERROR;
                        end else begin
                            for (int i = 0; i < 8; i++) begin
                                if (sample_ch == 3'(i))
                                    shadow_d[i*15 +: 15] = abs_word;
                            end
                            if (s_is_min)
                                sat_d = 1'b1;
                            if ((bitmap_q | (8'h01 << sample_ch)) == 8'hFF) begin
                                commit         = 1'b1;
                                concat_d       = shadow_d;
                                concat_valid_d = 1'b1;
                                bitmap_d       = 8'h00;
                                done_d         = 1'b1;
                                state_d        = RUN;
                            end else begin
                                bitmap_d[sample_ch] = 1'b1;
                            end
                        end
                    end
                    // Stall watchdog only runs once the stream has proven itself with one set.
                    if (state_q == RUN) begin
                        if (commit) begin
                            cnt_d = 16'd0;
                        end else if (cnt_q == CNT_LAST) begin
                            err_to_d = 1'b1;
                            state_d  = ERROR;
                        end else if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            bitmap_q       <= 8'h00;
            shadow_q       <= '0;
            concat_q       <= '0;
            cnt_q          <= 16'd0;
            concat_valid_q <= 1'b0;
            done_q         <= 1'b0;
            err_dup_q      <= 1'b0;
            err_to_q       <= 1'b0;
            sat_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            bitmap_q       <= bitmap_d;
            shadow_q       <= shadow_d;
            concat_q       <= concat_d;
            cnt_q          <= cnt_d;
            concat_valid_q <= concat_valid_d;
            done_q         <= done_d;
            err_dup_q      <= err_dup_d;
            err_to_q       <= err_to_d;
            sat_q          <= sat_d;
        end
    end

    assign abs_sample_concat = concat_q;
    assign concat_valid      = concat_valid_q;
    assign sample_core_done  = done_q;
    assign err_duplicate     = err_dup_q;
    assign err_timeout       = err_to_q;
    assign abs_saturated     = sat_q;

endmodule

// File: tb/tb_shim_abs_sample_collector.sv
// Directed bench for shim_abs_sample_collector: two's-complement and offset-binary instances
// share one stimulus stream; expected lane values are worked out by hand.
module tb_shim_abs_sample_collector;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         sample_valid = 1'b0;
    logic [2:0]   sample_ch = 3'd0;
    logic [15:0]  sample_data = 16'd0;

    logic [119:0] concat, concat_ob;
    logic         cvalid, cvalid_ob;
    logic         done, done_ob;
    logic         edup, edup_ob;
    logic         eto, eto_ob;
    logic         sat, sat_ob;

    int checks = 0;
    int errors = 0;

    shim_abs_sample_collector #(.OFFSET_BINARY(1'b0), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data),
        .abs_sample_concat(concat), .concat_valid(cvalid), .sample_core_done(done),
        .err_duplicate(edup), .err_timeout(eto), .abs_saturated(sat)
    );

    shim_abs_sample_collector #(.OFFSET_BINARY(1'b1), .TIMEOUT(64)) dut_ob (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data),
        .abs_sample_concat(concat_ob), .concat_valid(cvalid_ob), .sample_core_done(done_ob),
        .err_duplicate(edup_ob), .err_timeout(eto_ob), .abs_saturated(sat_ob)
    );

    always #5 clk = ~clk;

    localparam logic [119:0] L1 = {15'd8, 15'd7, 15'd6, 15'd5, 15'd4, 15'd3, 15'd2, 15'd1};
    localparam logic [119:0] L2 = {15'd100, 15'd1, 15'd32767, 15'd32767,
                                   15'd200, 15'd32767, 15'd0, 15'd300};
    localparam logic [119:0] L5 = {15'd16384, 15'd5, 15'd5, 15'd1,
                                   15'd1, 15'd32767, 15'd0, 15'd32767};
    localparam logic [119:0] L5TC = {15'd16384, 15'd32763, 15'd32763, 15'd32767,
                                     15'd32767, 15'd1, 15'd32767, 15'd0};
    localparam logic [119:0] L6 = {15'd18, 15'd17, 15'd16, 15'd15,
                                   15'd14, 15'd13, 15'd12, 15'd11};

    task automatic check_w(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] ch, input logic [15:0] d);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic apply_reset();
        sample_valid = 1'b0;
        enable       = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_t1_set();
        send(3'd0, 16'hFFFF); send(3'd1, 16'd2); send(3'd2, 16'hFFFD); send(3'd3, 16'd4);
        send(3'd4, 16'hFFFB); send(3'd5, 16'd6); send(3'd6, 16'hFFF9); send(3'd7, 16'd8);
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check_w("async_reset_concat", concat, 120'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_b("reset_valid", cvalid, 1'b0);
        check_b("reset_done", done, 1'b0);
        check_b("reset_dup", edup, 1'b0);
        check_b("reset_to", eto, 1'b0);
        check_b("reset_sat", sat, 1'b0);

        // T1: in-order set
        send_t1_set();
        check_b("idle_ignores_valid", cvalid, 1'b0);
        enable = 1'b1;
        tick();
        send(3'd0, 16'hFFFF); send(3'd1, 16'd2); send(3'd2, 16'hFFFD); send(3'd3, 16'd4);
        send(3'd4, 16'hFFFB); send(3'd5, 16'd6); send(3'd6, 16'hFFF9);
        check_w("t1_partial_hidden", concat, 120'd0);
        check_b("t1_partial_novalid", cvalid, 1'b0);
        check_b("t1_done_before", done, 1'b0);
        send(3'd7, 16'd8);
        check_b("t1_valid", cvalid, 1'b1);
        check_w("t1_concat", concat, L1);
        check_b("t1_done", done, 1'b1);
        check_b("t1_nosat", sat, 1'b0);
        tick();
        check_b("t1_valid_pulse", cvalid, 1'b0);
        check_w("t1_concat_hold", concat, L1);

        // T2: out-of-order with a saturating word
        send(3'd7, 16'd100); send(3'd3, 16'hFF38); send(3'd0, 16'd300); send(3'd2, 16'h8000);
        check_b("t2_sat_set", sat, 1'b1);
        check_w("t2_partial_hidden", concat, L1);
        send(3'd6, 16'hFFFF); send(3'd1, 16'd0); send(3'd5, 16'h7FFF); send(3'd4, 16'h8001);
        check_b("t2_valid", cvalid, 1'b1);
        check_w("t2_concat", concat, L2);

        // T4: commit landing on the expiring cycle, then a real stall
        repeat (56) tick();
        check_b("t4_no_to_early", eto, 1'b0);
        send_t1_set();
        check_b("t4_late_commit", cvalid, 1'b1);
        check_w("t4_late_concat", concat, L1);
        check_b("t4_commit_wins", eto, 1'b0);
        repeat (63) tick();
        check_b("t4_to_cycle63", eto, 1'b0);
        tick();
        check_b("t4_to_cycle64", eto, 1'b1);
        send(3'd7, 16'd100); send(3'd3, 16'hFF38); send(3'd0, 16'd300); send(3'd2, 16'h8000);
        send(3'd6, 16'hFFFF); send(3'd1, 16'd0); send(3'd5, 16'h7FFF); send(3'd4, 16'h8001);
        check_b("t4_error_novalid", cvalid, 1'b0);
        check_w("t4_error_frozen", concat, L1);
        check_b("t4_dup_clear", edup, 1'b0);

        // T3: duplicate channel
        apply_reset();
        check_w("t3_reset_concat", concat, 120'd0);
        check_b("t3_reset_to", eto, 1'b0);
        enable = 1'b1;
        tick();
        send_t1_set();
        check_w("t3_commit", concat, L1);
        send(3'd0, 16'd9); send(3'd1, 16'd9); send(3'd2, 16'd9); send(3'd3, 16'd9);
        send(3'd4, 16'd9); send(3'd5, 16'd9);
        check_b("t3_no_dup_yet", edup, 1'b0);
        send(3'd5, 16'd9);
        check_b("t3_dup", edup, 1'b1);
        check_w("t3_concat_kept", concat, L1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(3'(i), 16'd3);
        check_b("t3_error_novalid", cvalid, 1'b0);
        check_w("t3_error_frozen", concat, L1);
        check_b("t3_dup_sticky", edup, 1'b1);
        check_b("t3_no_to", eto, 1'b0);

        // T6: enable drop mid-set, then async reset mid-set
        apply_reset();
        enable = 1'b1;
        tick();
        send_t1_set();
        check_b("t6_done_up", done, 1'b1);
        send(3'd0, 16'd50); send(3'd1, 16'd50); send(3'd2, 16'd50); send(3'd3, 16'd50);
        enable       = 1'b0;
        sample_valid = 1'b1;
        sample_ch    = 3'd4;
        sample_data  = 16'd50;
        tick();
        sample_valid = 1'b0;
        check_b("t6_done_down", done, 1'b0);
        check_b("t6_no_valid", cvalid, 1'b0);
        check_w("t6_concat_kept", concat, L1);
        enable = 1'b1;
        tick();
        send(3'd4, 16'd15); send(3'd5, 16'd16); send(3'd6, 16'd17); send(3'd7, 16'd18);
        check_b("t6_bitmap_cleared", cvalid, 1'b0);
        check_w("t6_old_kept", concat, L1);
        send(3'd0, 16'd11); send(3'd1, 16'd12); send(3'd2, 16'd13); send(3'd3, 16'd14);
        check_b("t6_new_valid", cvalid, 1'b1);
        check_w("t6_new_concat", concat, L6);
        check_b("t6_dup_clear", edup, 1'b0);
        sample_valid = 1'b1;
        sample_ch    = 3'd1;
        sample_data  = 16'd77;
        #2 reset = 1'b1;
        #1;
        check_w("t6_async_concat", concat, 120'd0);
        check_b("t6_async_done", done, 1'b0);
        sample_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_w("t6_after_release", concat, 120'd0);

        // T5: offset-binary instance alongside the two's-complement one
        apply_reset();
        check_b("t5_reset_sat_ob", sat_ob, 1'b0);
        enable = 1'b1;
        tick();
        send(3'd0, 16'h0000); send(3'd1, 16'h8000); send(3'd2, 16'hFFFF); send(3'd3, 16'h8001);
        send(3'd4, 16'h7FFF); send(3'd5, 16'h8005); send(3'd6, 16'h7FFB); send(3'd7, 16'hC000);
        check_b("t5_ob_valid", cvalid_ob, 1'b1);
        check_w("t5_ob_concat", concat_ob, L5);
        check_b("t5_ob_sat", sat_ob, 1'b1);
        check_b("t5_ob_done", done_ob, 1'b1);
        check_w("t5_tc_concat", concat, L5TC);
        check_b("t5_tc_sat", sat, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
